// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared encodings for the pc_sequencer slice (branch ops, reset PC, sequencer states)
package pc_seq_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // RUN: PC advances; HOLD: stalled, nothing pending; PEND: stalled with a captured redirect
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode/compare inputs and PC outputs of the pc_sequencer, with master/slave views
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26
);
    import pc_seq_pkg::*;

    logic              stall_i;
    logic              br_valid;
    logic [2:0]        br_op;
    logic [ADDR_W-1:0] rs_val;
    logic [ADDR_W-1:0] rt_val;
    logic [IMM_W-1:0]  imm;
    logic              j_valid;
    logic [JIDX_W-1:0] j_idx;
    logic              jr_valid;
    logic [ADDR_W-1:0] jr_tgt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc4_o;
    logic [ADDR_W-1:0] npc_o;
    logic              taken_o;
    logic              misalign_o;

    modport master (
        output stall_i, br_valid, br_op, rs_val, rt_val, imm, j_valid, j_idx,
               jr_valid, jr_tgt, redirect_valid, redirect_pc,
        input  pc_o, pc4_o, npc_o, taken_o, misalign_o
    );

    modport slave (
        input  stall_i, br_valid, br_op, rs_val, rt_val, imm, j_valid, j_idx,
               jr_valid, jr_tgt, redirect_valid, redirect_pc,
        output pc_o, pc4_o, npc_o, taken_o, misalign_o
    );

endinterface

// File: rtl/br_cmp.sv
// br_cmp: combinational branch condition, equality or signed compare against zero selected by br_op
module br_cmp
    import pc_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   br_op,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    output logic         taken
);

    logic neg, zero;

    // sign and zero of rs decide the four compare-with-zero kinds
    always_comb begin
        neg   = rs_val[W-1];
        zero  = rs_val == '0;
        taken = br_op == BR_BEQ  ? rs_val == rt_val :
                br_op == BR_BNE  ? rs_val != rt_val :
                br_op == BR_BLEZ ? neg | zero :
                br_op == BR_BGTZ ? ~neg & ~zero :
                br_op == BR_BLTZ ? neg :
                br_op == BR_BGEZ ? ~neg : 1'b0;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with branch/jump/redirect resolution and stall-pending redirect.
// Optional MIPS delay slot enabled by defining PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                IMM_W    = 16,
    parameter int                JIDX_W   = 26
) (
    input logic          clk,
    input logic          reset,
    pc_sequencer_if.slave bus
);

    logic [ADDR_W-1:0] pc, pc4, br_tgt, j_tgt, xfer_tgt, npc, pend_pc;
    logic              pend_q, cmp_taken, xfer, taken;
    logic [1:0]        state;

    br_cmp #(.W(ADDR_W)) u_cmp (
        .br_op  (bus.br_op),
        .rs_val (bus.rs_val),
        .rt_val (bus.rt_val),
        .taken  (cmp_taken)
    );

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic              slot_q;
    logic [ADDR_W-1:0] slot_tgt;
`endif

    // target arithmetic and priority select; a live redirect also beats an older pending one
    always_comb begin
        pc4      = pc + ADDR_W'(4);
        br_tgt   = pc4 + {{(ADDR_W-IMM_W-2){bus.imm[IMM_W-1]}}, bus.imm, 2'b00};
        j_tgt    = {pc4[ADDR_W-1:JIDX_W+2], bus.j_idx, 2'b00};
        xfer     = bus.jr_valid | bus.j_valid | (bus.br_valid & cmp_taken);
        xfer_tgt = bus.jr_valid ? bus.jr_tgt : bus.j_valid ? j_tgt : br_tgt;
        state    = bus.stall_i ? (pend_q ? PEND : HOLD) : RUN;
`ifdef PC_SEQ_DELAY_SLOT_EN
        npc      = bus.redirect_valid ? bus.redirect_pc : pend_q ? pend_pc : slot_q ? slot_tgt : pc4;
        taken    = bus.redirect_valid | pend_q | (xfer & ~slot_q);
`else
        npc      = bus.redirect_valid ? bus.redirect_pc : pend_q ? pend_pc : xfer ? xfer_tgt : pc4;
        taken    = bus.redirect_valid | pend_q | xfer;
`endif
    end

    assign bus.pc_o       = pc;
    assign bus.pc4_o      = pc4;
    assign bus.npc_o      = npc;
    assign bus.taken_o    = taken;
    assign bus.misalign_o = |npc[1:0];

    // PC advances in RUN; while stalled a redirect is captured and the newest one kept
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_PC;
            pend_q  <= 1'b0;
            pend_pc <= '0;
        end else if (state == RUN) begin
            pc      <= npc;
            pend_q  <= 1'b0;
        end else if (bus.redirect_valid) begin
            pend_q  <= 1'b1;
            pend_pc <= bus.redirect_pc;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    // a resolved transfer parks its target for one instruction; redirects cancel the slot
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q   <= 1'b0;
            slot_tgt <= '0;
        end else if (state == RUN) begin
            slot_q   <= ~bus.redirect_valid & ~pend_q & ~slot_q & xfer;
            if (xfer && !slot_q) slot_tgt <= xfer_tgt;
        end
    end
`endif

endmodule
